// File: rtl/alu_md_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package alu_md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_radix2_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted  = {rem, dividend_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/alu_md.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and single-cycle MTHI/MTLO.
//   state   | meaning
//   ST_IDLE | waiting for start
//   ST_BUSY | one radix-2 step per cycle, WIDTH steps
//   ST_DONE | one-cycle result pulse; may accept a new start
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t        state;
    logic [CW-1:0]    cnt;
    logic             is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0] opnd, a_orig, acc_hi, acc_lo;

    logic             in_signed;
    logic [WIDTH-1:0] a_mag, b_mag, addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, rem_n, div_lo_n, quo, rmd;
    logic             q_bit;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res_hi, res_lo;

    div_radix2_step #(.WIDTH(WIDTH)) u_div_step (
        .rem          (acc_hi),
        .dividend_bit (acc_lo[WIDTH-1]),
        .divisor      (opnd),
        .rem_next     (rem_n),
        .q_bit        (q_bit)
    );

    always_comb begin
        in_signed = is_signed_op(op);
        a_mag     = (in_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (in_signed && b[WIDTH-1]) ? -b : b;

        // Multiply: conditional add into the upper half, then shift {carry,hi,lo} right.
        addend   = acc_lo[0] ? opnd : '0;
        sum      = {1'b0, acc_hi} + {1'b0, addend};
        mul_hi_n = sum[WIDTH:1];
        mul_lo_n = {sum[0], acc_lo[WIDTH-1:1]};
        div_lo_n = {acc_lo[WIDTH-2:0], q_bit};

        prod = {mul_hi_n, mul_lo_n};
        if (neg_q) prod = -prod;
        quo = neg_q ? -div_lo_n : div_lo_n;
        rmd = neg_r ? -rem_n : rem_n;
        if (div_zero) begin
            quo = '1;
            rmd = a_orig;
        end

        res_hi = is_div ? rmd : prod[2*WIDTH-1:WIDTH];
        res_lo = is_div ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            a_orig   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start && is_iter_op(op)) begin
                        state    <= ST_BUSY;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        is_div   <= is_div_op(op);
                        neg_q    <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= in_signed && a[WIDTH-1];
                        div_zero <= (b == '0);
                        a_orig   <= a;
                        acc_hi   <= '0;
                        // Multiply keeps the multiplier in acc_lo; divide shifts the dividend out of it.
                        opnd     <= is_div_op(op) ? b_mag : a_mag;
                        acc_lo   <= is_div_op(op) ? a_mag : b_mag;
                    end else if (start && op == MD_MTHI) begin
                        hi <= a;
                    end else if (start && op == MD_MTLO) begin
                        lo <= a;
                    end
                end
                ST_BUSY: begin
                    cnt    <= cnt + CW'(1);
                    acc_hi <= is_div ? rem_n : mul_hi_n;
                    acc_lo <= is_div ? div_lo_n : mul_lo_n;
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= res_hi;
                        lo    <= res_lo;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md at WIDTH=32.
module tb_alu_md;
    import alu_md_pkg::*;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;
    logic [63:0] sb[$];

    alu_md #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (mop)
            MD_MULT:  return 64'(sx * sy);
            MD_MULTU: return ux * uy;
            MD_DIVU:  return (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(ux % uy), 32'(ux / uy)};
            MD_DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Called at a falling edge; leaves inputs idle at the next falling edge (cycle k+1).
    task automatic drive_start(input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = mop;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = MD_NONE;
    endtask

    task automatic wait_done(output int busy_cycles, output bit timed_out);
        busy_cycles = 0;
        timed_out   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        op     = MD_NONE;
        a      = '0;
        b      = '0;
        flush  = 1'b0;
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_timing();
        int bc;
        bit to;
        logic [63:0] exp;
        sb.push_back(64'hFFFF_FFFE_0000_0001);
        drive_start(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc, to);
        exp = sb.pop_front();
        total++; if (to) begin bad++; $display("FAIL multu_timeout got=no_done exp=done"); end
        total++; if (bc != 32) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=32", bc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_at_done got=%b exp=0", busy); end
        total++; if ({hi, lo} !== exp) begin bad++; $display("FAIL multu_result got=%h exp=%h", {hi, lo}, exp); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_mult_div();
        logic [2:0]  t_op[6] = '{MD_MULT, MD_DIV, MD_DIVU, MD_DIV, MD_DIV, MD_DIVU};
        logic [31:0] t_a[6]  = '{32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'h7, 32'h8000_0000, 32'hFFFF_FFFB, 32'd100};
        logic [31:0] t_b[6]  = '{32'h3, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'd7};
        logic [63:0] t_e[6]  = '{64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0007_FFFF_FFFF,
                                 64'h0000_0000_8000_0000, 64'hFFFF_FFFB_FFFF_FFFF, 64'h0000_0002_0000_000E};
        int bc;
        bit to;
        logic [63:0] exp;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(t_e[i]);
            drive_start(t_op[i], t_a[i], t_b[i]);
            wait_done(bc, to);
            exp = sb.pop_front();
            total++;
            if (to || {hi, lo} !== exp) begin
                bad++;
                $display("FAIL case%0d_result got=%h exp=%h timeout=%0d", i, {hi, lo}, exp, to);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1; op = MD_MTHI; a = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
        total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi_value got=%h exp=12345678", hi); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mthi_flags got=%b%b exp=00", busy, done); end
        start = 1'b1; op = MD_MTLO; a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
        total++; if (lo !== 32'h9ABC_DEF0) begin bad++; $display("FAIL mtlo_value got=%h exp=9abcdef0", lo); end
        total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", hi); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mtlo_flags got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_flush();
        int done_seen;
        int busy_seen;
        drive_start(MD_DIVU, 32'd100, 32'd7);
        for (int i = 1; i < 5; i++) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy_c5 got=%b exp=1", busy); end
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd5;
        for (int i = 5; i < 10; i++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0; op = MD_NONE;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy_after got=%b exp=0", busy); end
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            if (busy) busy_seen++;
            @(negedge clk);
        end
        total++; if (done_seen != 0) begin bad++; $display("FAIL flush_done_pulses got=%0d exp=0", done_seen); end
        total++; if (busy_seen != 0) begin bad++; $display("FAIL flush_busy_later got=%0d exp=0", busy_seen); end
        total++; if ({hi, lo} !== 64'h1234_5678_9ABC_DEF0) begin bad++; $display("FAIL flush_hilo_kept got=%h exp=123456789abcdef0", {hi, lo}); end
    endtask

    task automatic test_async_reset();
        int bc;
        bit to;
        logic [63:0] exp;
        drive_start(MD_MULT, 32'd3, 32'd5);
        for (int i = 1; i < 5; i++) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL areset_flags got=%b%b exp=00", busy, done); end
        total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL areset_hilo got=%h exp=0", {hi, lo}); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        sb.push_back(64'h0000_0002_0000_000E);
        drive_start(MD_DIVU, 32'd100, 32'd7);
        wait_done(bc, to);
        exp = sb.pop_front();
        total++; if (to || {hi, lo} !== exp) begin bad++; $display("FAIL areset_divu got=%h exp=%h timeout=%0d", {hi, lo}, exp, to); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int bc;
        bit to;
        logic [63:0] exp;
        sb.push_back(model(MD_MULTU, 32'h0000_1234, 32'h0000_5678));
        sb.push_back(model(MD_DIVU, 32'd1000, 32'd3));
        drive_start(MD_MULTU, 32'h0000_1234, 32'h0000_5678);
        wait_done(bc, to);
        exp = sb.pop_front();
        total++; if (to || {hi, lo} !== exp) begin bad++; $display("FAIL b2b_first got=%h exp=%h timeout=%0d", {hi, lo}, exp, to); end
        drive_start(MD_DIVU, 32'd1000, 32'd3);
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b%b exp=10", busy, done); end
        wait_done(bc, to);
        exp = sb.pop_front();
        total++; if (to || {hi, lo} !== exp) begin bad++; $display("FAIL b2b_second got=%h exp=%h timeout=%0d", {hi, lo}, exp, to); end
        total++; if (bc != 32) begin bad++; $display("FAIL b2b_busy_cycles got=%0d exp=32", bc); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0]  ops[4] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int bc;
        bit to;
        logic [63:0] exp;
        for (int i = 0; i < 12; i++) begin
            rop = ops[$urandom_range(0, 3)];
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (rb[0] && i % 2 == 1) rb = -rb;
            sb.push_back(model(rop, ra, rb));
            drive_start(rop, ra, rb);
            wait_done(bc, to);
            exp = sb.pop_front();
            total++;
            if (to || {hi, lo} !== exp) begin
                bad++;
                $display("FAIL rand%0d op=%0d a=%h b=%h got=%h exp=%h timeout=%0d", i, rop, ra, rb, {hi, lo}, exp, to);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_multu_timing();
        test_mult_div();
        test_mthi_mtlo();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_md.md
# alu_md

Iterative multiply/divide unit with architectural HI/LO registers, the sequential companion to the combinational EX-stage ALU. Executes MULT/MULTU/DIV/DIVU over WIDTH cycles with a start/busy/done handshake and handles MTHI/MTLO in one cycle. It sits in the EX stage; the pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- WIDTH, 32, operand and HI/LO width (≥ 4).
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when the unit can accept (state IDLE or DONE).
- op  in  3  operation code from `alu_md_pkg`: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  abort any in-flight operation (exception/branch squash).
- busy  out  1  registered; high while an iterative op is in flight.
- done  out  1  registered; one-cycle pulse when an iterative result is written.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, BUSY, DONE. Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
- IDLE/DONE + start + MULT/MULTU/DIV/DIVU: latch operands (magnitudes and sign flags for signed ops), counter=0, go BUSY.
- IDLE/DONE + start + MTHI: hi←a next edge; MTLO: lo←a; stay/return IDLE, busy and done stay 0.
- start with MD_NONE, or start in BUSY: ignored, no state change.
- BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide); counter increments; after step WIDTH-1 go DONE and write hi/lo on that same edge.
- DONE: lasts exactly one cycle, then IDLE unless a new start is accepted.
- MULT: 2·WIDTH-bit two's-complement product {hi,lo}. MULTU: unsigned product.
- DIVU: lo=quotient, hi=remainder. DIV: divide magnitudes; quotient negated iff operand signs differ; remainder takes sign of dividend (truncating division).
- Divide by zero (any sign): lo=all ones, hi=a. Most-negative / -1 for DIV: lo=most-negative, hi=0 (natural wrap).
- flush: highest priority; from any state go IDLE next edge, busy=0, done=0; hi/lo not written; a start in the same cycle as flush is dropped.
- flush does not cancel an MTHI/MTLO already written.
- resetn low mid-operation: immediate return to reset values; partial result discarded.

## Timing
- Accept at edge k → busy=1 in cycles k+1..k+WIDTH; done=1 and hi/lo new in cycle k+WIDTH+1; busy=0 in that cycle.
- Back-to-back: start in the DONE cycle is accepted; busy rises the next cycle, done falls.
- MTHI/MTLO: value visible on hi/lo the cycle after start.
- Outputs are all registered; no combinational path from inputs to outputs.

## Structure
- `alu_md_pkg`: op encoding localparams (3-bit), state enum encoding, WIDTH-independent constants.
- One sub-module `div_radix2_step`: combinational single restoring-division step (partial remainder, divisor → next remainder, quotient bit), parametrised by WIDTH. Multiply step stays inline.
- Sign fix-up and divide-by-zero override live in alu_md at the BUSY→DONE write.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → done in cycle k+33, hi=0xFFFFFFFE lo=0x00000001; busy high exactly 32 cycles.
- MULT a=0xFFFFFFFE (-2) b=3 → hi=0xFFFFFFFF lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=0 → lo=0xFFFFFFFF hi=0x00000007.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 → hi/lo show values one cycle after each start; busy/done stay 0.
- DIVU 100/7 started, flush at busy cycle 10, start asserted mid-BUSY → done never pulses, hi/lo keep prior values, busy=0 next cycle, mid-BUSY start ignored.
- resetn pulled low at busy cycle 5 of MULT → busy/done/hi/lo=0 immediately; new DIVU 100/7 after release → lo=14 hi=2.
